// File: rtl/serial_subtract_ctrl_pkg.sv
// serial_subtract_ctrl_pkg: shared FSM state encoding and WIDTH bounds
//   state_t   : IDLE=0, SHIFT=1, DONE=2
//   WIDTH_MIN / WIDTH_MAX : legal operand width range
package serial_subtract_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/serial_subtract_ctrl_cell.sv
// serial_subtract_ctrl_cell: one-bit full subtractor built from two half subtractors
//   half_subtract : x, y -> d = x^y, b = ~x&y
//   full_subtract : ai, bi, bin -> d = ai^bi^bin, bout = borrow of ai-bi-bin
module half_subtract (
    input  logic x,
    input  logic y,
    output logic d,
    output logic b
);
    assign d = x ^ y;
    assign b = ~x & y;
endmodule

module full_subtract (
    input  logic ai,
    input  logic bi,
    input  logic bin,
    output logic d,
    output logic bout
);
    logic d1, b1, b2;
    half_subtract u_hs0 (.x(ai), .y(bi),  .d(d1), .b(b1));
    half_subtract u_hs1 (.x(d1), .y(bin), .d(d),  .b(b2));
    assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtract_ctrl.sv
// serial_subtract_ctrl: bit-serial A-B, LSB first, one bit per clock through one shared cell
//   clk, rst (async, active high)
//   start      : sample a/b and begin (accepted in IDLE or DONE only)
//   a, b       : minuend / subtrahend
//   busy       : high while bits are processed
//   done       : one-cycle pulse, diff/bout valid
//   diff, bout : (a-b) mod 2^WIDTH, borrow (a<b)
module serial_subtract_ctrl
    import serial_subtract_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
);
    localparam int CW = $clog2(WIDTH) + 1;

    state_t           state, nxt;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] a_sr, b_sr, d_sr, d_next;
    logic             borrow, cell_d, cell_b, accept, last;

    full_subtract u_cell (
        .ai  (a_sr[0]),
        .bi  (b_sr[0]),
        .bin (borrow),
        .d   (cell_d),
        .bout(cell_b)
    );

    always_comb begin
        accept = start && state != SHIFT;
        last   = cnt == CW'(WIDTH - 1);
        // new bit enters at the MSB end; written as a shift so WIDTH=1 needs no special case
        d_next = WIDTH'({cell_d, d_sr} >> 1);
        nxt    = state == SHIFT ? (last ? DONE : SHIFT) : (accept ? SHIFT : IDLE);
        busy   = state == SHIFT;
        done   = state == DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            bout   <= 1'b0;
        end else begin
            state <= nxt;
            if (accept) begin
                a_sr   <= a;
                b_sr   <= b;
                d_sr   <= '0;
                borrow <= 1'b0;
                cnt    <= '0;
            end else if (state == SHIFT) begin
                a_sr   <= a_sr >> 1;
                b_sr   <= b_sr >> 1;
                d_sr   <= d_next;
                borrow <= cell_b;
                cnt    <= cnt + 1'b1;
                // only the final bit publishes, so partial results never reach diff
                if (last) begin
                    diff <= d_next;
                    bout <= cell_b;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_subtract_ctrl.sv
// tb_serial_subtract_ctrl: directed and randomized checks of serial_subtract_ctrl at WIDTH 1/8/16
module tb_serial_subtract_ctrl;
    import serial_subtract_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  start = '0;
    logic [31:0] a_bus = '0, b_bus = '0;

    logic        busy1, done1, bout1, busy8, done8, bout8, busy16, done16, bout16;
    logic [0:0]  diff1;
    logic [7:0]  diff8;
    logic [15:0] diff16;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    serial_subtract_ctrl #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a_bus[0:0]), .b(b_bus[0:0]),
        .busy(busy1), .done(done1), .diff(diff1), .bout(bout1));
    serial_subtract_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a_bus[7:0]), .b(b_bus[7:0]),
        .busy(busy8), .done(done8), .diff(diff8), .bout(bout8));
    serial_subtract_ctrl #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start[2]), .a(a_bus[15:0]), .b(b_bus[15:0]),
        .busy(busy16), .done(done16), .diff(diff16), .bout(bout16));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int wid(input int s);
        return s == 0 ? 1 : (s == 1 ? 8 : 16);
    endfunction

    function automatic logic o_done(input int s);
        return s == 0 ? done1 : (s == 1 ? done8 : done16);
    endfunction

    function automatic logic o_busy(input int s);
        return s == 0 ? busy1 : (s == 1 ? busy8 : busy16);
    endfunction

    function automatic logic o_bout(input int s);
        return s == 0 ? bout1 : (s == 1 ? bout8 : bout16);
    endfunction

    function automatic logic [31:0] o_diff(input int s);
        return s == 0 ? {31'b0, diff1} : (s == 1 ? {24'b0, diff8} : {16'b0, diff16});
    endfunction

    task automatic issue(input int s, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        a_bus    = av;
        b_bus    = bv;
        start[s] = 1'b1;
        @(negedge clk);
        start[s] = 1'b0;
    endtask

    // waits (bounded) for done; n counts cycles since the edge that sampled start
    task automatic wait_done(input int s, input int n0, output int n, output bit busy_bad);
        n = n0;
        busy_bad = 0;
        while (!o_done(s) && n < 64) begin
            if (o_busy(s) !== 1'b1) busy_bad = 1;
            @(negedge clk);
            n++;
        end
    endtask

    task automatic expect_result(input string tag, input int s, input logic [31:0] av, input logic [31:0] bv);
        longint mask;
        longint am, bm;
        mask = (64'd1 << wid(s)) - 1;
        am = longint'(av) & mask;
        bm = longint'(bv) & mask;
        check({tag, "_diff"}, 64'(o_diff(s)), 64'((am - bm) & mask));
        check({tag, "_bout"}, 64'(o_bout(s)), 64'(am < bm));
    endtask

    task automatic run_op(input string tag, input int s, input logic [31:0] av, input logic [31:0] bv);
        int  n;
        bit  bb;
        issue(s, av, bv);
        wait_done(s, 1, n, bb);
        check({tag, "_latency"}, 64'(n), 64'(wid(s) + 1));
        check({tag, "_busy_window"}, 64'(bb), 64'd0);
        check({tag, "_busy_in_done"}, 64'(o_busy(s)), 64'd0);
        expect_result(tag, s, av, bv);
    endtask

    initial begin
        int  n;
        int  extra;
        bit  bb;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy8), 64'd0);
        check("reset_done", 64'(done8), 64'd0);
        check("reset_diff", 64'(diff8), 64'd0);
        check("reset_bout", 64'(bout8), 64'd0);
        check("reset_state", 64'(dut8.state), 64'(IDLE));
        rst = 1'b0;

        run_op("t1_5a_23", 1, 32'h5A, 32'h23);
        check("t1_diff_const", 64'(diff8), 64'h37);
        run_op("t2_00_01", 1, 32'h00, 32'h01);
        check("t2_borrow_const", 64'({bout8, diff8}), 64'h1FF);
        run_op("t2_80_80", 1, 32'h80, 32'h80);

        // start during SHIFT must be ignored
        issue(1, 32'h5A, 32'h23);
        @(negedge clk);
        @(negedge clk);
        a_bus = 32'hFF;
        b_bus = 32'h00;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        wait_done(1, 4, n, bb);
        check("t3_latency", 64'(n), 64'd9);
        check("t3_diff", 64'(diff8), 64'h37);
        check("t3_bout", 64'(bout8), 64'd0);
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) extra++;
        end
        check("t3_no_second_done", 64'(extra), 64'd0);
        check("t3_diff_held", 64'(diff8), 64'h37);

        // back-to-back start in the DONE cycle
        issue(1, 32'h5A, 32'h23);
        wait_done(1, 1, n, bb);
        check("t4_first_done", 64'(done8), 64'd1);
        a_bus = 32'h10;
        b_bus = 32'h20;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        check("t4_done_drops", 64'(done8), 64'd0);
        check("t4_busy_rises", 64'(busy8), 64'd1);
        check("t4_state", 64'(dut8.state), 64'(SHIFT));
        wait_done(1, 1, n, bb);
        check("t4_latency", 64'(n), 64'd9);
        check("t4_diff", 64'(diff8), 64'hF0);
        check("t4_bout", 64'(bout8), 64'd1);

        // asynchronous reset mid-SHIFT
        issue(1, 32'hC3, 32'h01);
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", 64'(busy8), 64'd0);
        check("t5_done", 64'(done8), 64'd0);
        check("t5_diff", 64'(diff8), 64'd0);
        check("t5_bout", 64'(bout8), 64'd0);
        check("t5_state", 64'(dut8.state), 64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        extra = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8) extra++;
        end
        check("t5_no_done", 64'(extra), 64'd0);
        run_op("t5_after", 1, 32'h5A, 32'h23);

        for (int i = 0; i < 1000; i++) begin
            int s;
            s = i % 3;
            run_op($sformatf("rand%0d_w%0d", i, wid(s)), s, $urandom, $urandom);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
